prio_enc_rr: RTL and testbench

Parametrised, registered priority encoder with an optional round-robin mode and a valid/ready output handshake. It generalises the team's 8-input fixed-priority encoder to N request lines. It keeps the same code convention: input index k (0-based) encodes as k+1, and 0 means no request. It sits between request sources (interrupt lines, channel requests) and a consumer that may stall, such as a DMA channel selector or interrupt dispatcher.

---
 rtl/prio_enc_rr.sv | 91 +++++++++
 tb/tb_prio_enc_rr.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-input priority encoder with fixed or round-robin
// arbitration and a valid/ready output stage.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request vector, bit k = source k (sampled on load cycles only)
//   mode       0 = fixed priority (highest index wins), 1 = round-robin
//   code       registered winner code (index+1), 0 when nothing captured
//   out_valid  code holds a captured grant
//   out_ready  consumer accepts code this cycle
//   multi      more than one request bit was set at capture
module prio_enc_rr #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic [CW-1:0] code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          multi
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last;
  logic [IW-1:0] fix_win_c;
  logic [IW-1:0] rr_win_c;
  logic [IW-1:0] win_c;
  logic          load_c;
  logic          any_c;
  logic          many_c;

  // The output stage refills whenever it is empty or being drained.
  assign load_c = !out_valid || out_ready;
  assign any_c  = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign many_c = |(req & (req - N'(1)));

  // Fixed priority: ascending scan, later hits overwrite, so the top index wins.
  always_comb begin
    fix_win_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i]) fix_win_c = IW'(i);
    end
  end

  // Round-robin: candidate at distance i below last (mod N). Scanning from the
  // farthest distance down lets the nearest hit below last win, which puts
  // last itself at the lowest priority.
  always_comb begin
    int            t;
    logic [IW-1:0] idx;
    rr_win_c = '0;
    t        = 0;
    idx      = '0;
    for (int i = int'(N); i >= 1; i--) begin
      t = int'(last) - i;
      if (t < 0) t = t + int'(N);
      idx = IW'(t);
      if (req[idx]) rr_win_c = idx;
    end
  end

  assign win_c = mode ? rr_win_c : fix_win_c;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code      <= '0;
      out_valid <= 1'b0;
      multi     <= 1'b0;
      last      <= '0;
    end else if (load_c) begin
      if (any_c) begin
        code      <= CW'(win_c) + CW'(1);
        out_valid <= 1'b1;
        multi     <= many_c;
        if (mode) last <= win_c;
      end else begin
        code      <= '0;
        out_valid <= 1'b0;
        multi     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: scoreboard bench for prio_enc_rr at N=8, N=2 and N=33.
// All three instances share stimulus; each has its own reference model state
// and expected-grant queue.
module tb_prio_enc_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] req = '0;
  logic        mode = 1'b0;
  logic        ready = 1'b1;

  logic [3:0]  code8;
  logic [1:0]  code2;
  logic [5:0]  code33;
  logic        v8, v2, v33;
  logic        m8, m2, m33;

  prio_enc_rr #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req[7:0]), .mode(mode),
    .code(code8), .out_valid(v8), .out_ready(ready), .multi(m8));

  prio_enc_rr #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req[1:0]), .mode(mode),
    .code(code2), .out_valid(v2), .out_ready(ready), .multi(m2));

  prio_enc_rr #(.N(33)) u33 (
    .clk(clk), .rst_n(rst_n), .req(req[32:0]), .mode(mode),
    .code(code33), .out_valid(v33), .out_ready(ready), .multi(m33));

  always #5 clk = ~clk;

  int   cd [3];
  logic vd [3];
  logic md [3];
  always_comb begin
    cd[0] = int'(code8);  vd[0] = v8;  md[0] = m8;
    cd[1] = int'(code2);  vd[1] = v2;  md[1] = m2;
    cd[2] = int'(code33); vd[2] = v33; md[2] = m33;
  end

  int nn [3] = '{8, 2, 33};
  int sb [3][$];   // expected grants, encoded as code*2 + multi
  bit mv [3];      // model: output register holds a grant
  int ml [3];      // model: last round-robin winner index

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (N=%0d) at %0t: got %0d, expected %0d", name, nn[d], $time, act, exp);
    end
  endtask

  // Reference winner: walk the priority order the arbitration rules describe.
  function automatic int ref_winner(input logic [63:0] r, input int n, input bit rr, input int lst);
    if (rr) begin
      for (int k = 1; k <= n; k++) begin
        int idx;
        idx = (lst - k + n) % n;
        if (r[idx]) return idx;
      end
    end else begin
      for (int idx = n - 1; idx >= 0; idx--) if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [63:0] nmask(input int n);
    if (n >= 64) return '1;
    return (64'(1) << n) - 64'(1);
  endfunction

  // Drive inputs for the next edge and predict what that edge captures.
  task automatic step(input logic [63:0] r, input bit m, input bit rd);
    @(posedge clk); #1;
    req = r; mode = m; ready = rd;
    n_vec++;
    for (int d = 0; d < 3; d++) begin
      logic [63:0] rm;
      int w;
      rm = r & nmask(nn[d]);
      if (!mv[d] || rd) begin
        w = ref_winner(rm, nn[d], m, ml[d]);
        if (w >= 0) begin
          sb[d].push_back((w + 1) * 2 + (($countones(rm) > 1) ? 1 : 0));
          mv[d] = 1'b1;
          if (m) ml[d] = w;
        end else begin
          mv[d] = 1'b0;
        end
      end
    end
  endtask

  // Asynchronous reset: outputs must clear with no clock edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_code", d, cd[d], 0);
      chk("reset_valid", d, int'(vd[d]), 0);
      chk("reset_multi", d, int'(md[d]), 0);
      sb[d].delete();
      mv[d] = 1'b0;
      ml[d] = 0;
    end
    req = '0; mode = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: a transfer happens at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (vd[d] && ready) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_grant", d, cd[d], 0);
          end else begin
            int e;
            e = sb[d].pop_front();
            chk("grant_code", d, cd[d], e / 2);
            chk("grant_multi", d, int'(md[d]), e % 2);
          end
        end else if (!vd[d]) begin
          chk("idle_code", d, cd[d], 0);
          chk("idle_multi", d, int'(md[d]), 0);
        end
      end
    end
  end

  initial begin
    do_reset();
    step('0, 0, 1);
    step('0, 0, 1);

    // Fixed priority basics.
    step(64'h81, 0, 1);
    step(64'h04, 0, 1);
    step(64'h00, 0, 1);
    step(64'h00, 0, 1);

    // Round-robin with everything requesting, then a two-source pattern.
    for (int i = 0; i < 11; i++) step('1, 1, 1);
    for (int i = 0; i < 3; i++) step(64'h44, 1, 1);

    // Mode switch with last retained.
    for (int i = 0; i < 3; i++) step('1, 1, 1);
    for (int i = 0; i < 3; i++) step('1, 0, 1);
    for (int i = 0; i < 2; i++) step('1, 1, 1);

    // Stall: later requests are ignored while held.
    step(64'h10, 0, 1);
    for (int i = 0; i < 4; i++) step(64'h80, 0, 0);
    step(64'h80, 0, 1);
    step(64'h00, 0, 1);
    step(64'h00, 0, 1);

    // Reset during a hold discards the pending grant.
    step(64'h10, 1, 1);
    step(64'h20, 1, 0);
    step(64'h20, 1, 0);
    do_reset();
    step('0, 0, 1);

    // One-hot sweep across all widths, both modes.
    for (int k = 0; k < 33; k++) step(64'(1) << k, k[0], 1);
    do_reset();
    for (int i = 0; i < 40; i++) step('1, 1, 1);

    // Randomized traffic with stalls, mode flips and occasional resets.
    begin
      bit m;
      m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic [63:0] r;
        int sel;
        r = {$urandom, $urandom};
        sel = int'($urandom_range(0, 7));
        case (sel)
          0: r = '0;
          1: r = 64'(1) << $urandom_range(0, 7);
          2: r = 64'(1) << $urandom_range(0, 32);
          3: r = r & {$urandom, $urandom} & {$urandom, $urandom};
          4: r = '1;
          5: r = r & 64'h3;
          default: ;
        endcase
        if ($urandom_range(0, 15) == 0) m = ~m;
        if ($urandom_range(0, 499) == 0) do_reset();
        step(r, m, $urandom_range(0, 3) != 0);
      end
    end

    // Drain and confirm every predicted grant was delivered.
    for (int i = 0; i < 3; i++) step('0, 0, 1);
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) chk("drain", d, sb[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
